// File: rtl/fetch_unit_vl.sv
// Program counter and fetch engine: reads bytes from a 1-cycle synchronous ROM,
// assembles 1- or 2-byte instructions and hands them to the decoder via valid/ready.
module fetch_unit_vl #(
  parameter int            PC_W     = 12,
  parameter int            OPC_W    = 4,
  parameter int            OPR_W    = 4,
  parameter bit            LONG_EN  = 1'b1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_load,
  input  logic [PC_W-1:0]        i_load_addr,
  output logic [PC_W-1:0]        o_mem_addr,
  input  logic [OPC_W+OPR_W-1:0] i_mem_data,
  output logic                   o_instr_valid,
  input  logic                   i_instr_ready,
  output logic [OPC_W-1:0]       o_opcode,
  output logic [OPR_W-1:0]       o_operand,
  output logic [OPC_W+OPR_W-1:0] o_imm,
  output logic                   o_is_long,
  output logic [PC_W-1:0]        o_instr_pc,
  output logic [PC_W-1:0]        o_pc
);

  // state  | meaning
  // S_REQ  | ROM addressed with pc; waiting for enable to start a fetch
  // S_CAP1 | first byte arriving; latch opcode/operand, decide length
  // S_CAP2 | immediate byte arriving
  // S_OUT  | instruction presented, waiting for the decoder
  typedef enum logic [1:0] {S_REQ, S_CAP1, S_CAP2, S_OUT} state_t;

  localparam int DATA_W = OPC_W + OPR_W;

  state_t             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_instr_pc;
  logic [OPC_W-1:0]   r_opcode;
  logic [OPR_W-1:0]   r_operand;
  logic [DATA_W-1:0]  r_imm;
  logic               r_is_long;
  logic               r_valid;

  logic               w_long;
  logic [PC_W-1:0]    w_pc_inc;

  assign w_long   = LONG_EN && i_mem_data[DATA_W-1];
  // Increment wraps naturally at 2^PC_W, so a long instruction at the top
  // address fetches its immediate from address 0.
  assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_instr_pc <= '0;
      r_opcode   <= '0;
      r_operand  <= '0;
      r_imm      <= '0;
      r_is_long  <= 1'b0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      // A jump discards whatever is in flight or waiting, even if accepted this cycle.
      r_state <= S_REQ;
      r_pc    <= i_load_addr;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_enable) begin
            r_instr_pc <= r_pc;
            r_pc       <= w_pc_inc;
            r_state    <= S_CAP1;
          end
        end
        S_CAP1: begin
          r_opcode  <= i_mem_data[DATA_W-1:OPR_W];
          r_operand <= i_mem_data[OPR_W-1:0];
          if (w_long) begin
            r_is_long <= 1'b1;
            r_pc      <= w_pc_inc;
            r_state   <= S_CAP2;
          end else begin
            r_imm     <= '0;
            r_is_long <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= S_OUT;
          end
        end
        S_CAP2: begin
          r_imm   <= i_mem_data;
          r_valid <= 1'b1;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (i_instr_ready) begin
            r_valid <= 1'b0;
            r_state <= S_REQ;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_REQ;
        end
      endcase
    end
  end

  assign o_mem_addr    = r_pc;
  assign o_pc          = r_pc;
  assign o_instr_valid = r_valid;
  assign o_opcode      = r_opcode;
  assign o_operand     = r_operand;
  assign o_imm         = r_imm;
  assign o_is_long     = r_is_long;
  assign o_instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_unit_vl.sv
// Scoreboard bench for fetch_unit_vl: stimulus pushes expected instructions,
// a negedge monitor pops and compares on every accepted handshake.
module tb_fetch_unit_vl;

  typedef struct packed {
    logic [3:0]  opc;
    logic [3:0]  opr;
    logic [7:0]  imm;
    logic        lng;
    logic [11:0] ipc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom [0:4095];
  exp_t        q1[$];
  exp_t        q2[$];
  int          checks = 0;
  int          errors = 0;

  // DUT 1: LONG_EN=1
  logic        en1, ld1, rdy1;
  logic [11:0] ldaddr1, maddr1, ipc1, pc1;
  logic [7:0]  mdata1, imm1;
  logic        val1, long1;
  logic [3:0]  opc1, opr1;

  // DUT 2: LONG_EN=0
  logic        en2, ld2, rdy2;
  logic [11:0] ldaddr2, maddr2, ipc2, pc2;
  logic [7:0]  mdata2, imm2;
  logic        val2, long2;
  logic [3:0]  opc2, opr2;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    mdata1 <= rom[maddr1];
    mdata2 <= rom[maddr2];
  end

  fetch_unit_vl #(.LONG_EN(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_enable(en1), .i_load(ld1), .i_load_addr(ldaddr1),
    .o_mem_addr(maddr1), .i_mem_data(mdata1), .o_instr_valid(val1), .i_instr_ready(rdy1),
    .o_opcode(opc1), .o_operand(opr1), .o_imm(imm1), .o_is_long(long1),
    .o_instr_pc(ipc1), .o_pc(pc1));

  fetch_unit_vl #(.LONG_EN(1'b0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_enable(en2), .i_load(ld2), .i_load_addr(ldaddr2),
    .o_mem_addr(maddr2), .i_mem_data(mdata2), .o_instr_valid(val2), .i_instr_ready(rdy2),
    .o_opcode(opc2), .o_operand(opr2), .o_imm(imm2), .o_is_long(long2),
    .o_instr_pc(ipc2), .o_pc(pc2));

  // Monitor: a transfer is a valid&ready cycle without a simultaneous jump.
  always @(negedge clk) begin
    exp_t e, a;
    if (rst && val1 && rdy1 && !ld1) begin
      a = '{opc1, opr1, imm1, long1, ipc1};
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected got %h expected nothing", a);
      end else begin
        e = q1.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL dut1_instr got %h expected %h", a, e);
        end
      end
    end
    if (rst && val2 && rdy2 && !ld2) begin
      a = '{opc2, opr2, imm2, long2, ipc2};
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dut2_unexpected got %h expected nothing", a);
      end else begin
        e = q2.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL dut2_instr got %h expected %h", a, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input bit which, output int lat);
    lat = 0;
    while (!(which ? val2 : val1) && lat < 20) begin
      step();
      lat++;
    end
    if (lat >= 20) begin
      checks++;
      errors++;
      $display("FAIL timeout_valid dut%0d got no valid expected valid", which ? 2 : 1);
    end
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[0]     = 8'h35;
    rom[4]     = 8'hA7;
    rom[5]     = 8'h5C;
    rom[6]     = 8'h12;
    rom[7]     = 8'h44;
    rom[10]    = 8'h3B;
    rom[20]    = 8'h11;
    rom[21]    = 8'h66;
    rom[12'h30] = 8'h5A;
    rom[12'h31] = 8'h77;
    rom[12'hFFF] = 8'h81;

    rst = 1'b0;
    {en1, ld1, rdy1, en2, ld2, rdy2} = '0;
    ldaddr1 = '0;
    ldaddr2 = '0;
    step(); step();
    rst = 1'b1;
    step();

    // Reset state
    chk("reset_pc", pc1, 0);
    chk("reset_valid", val1, 0);
    chk("reset_outs", {opc1, opr1, imm1, long1, ipc1}, 0);
    chk("reset_pc_dut2", pc2, 0);

    // 1: short instruction at 0, 2-cycle latency
    q1.push_back('{4'h3, 4'h5, 8'h00, 1'b0, 12'h000});
    en1 = 1'b1; rdy1 = 1'b1;
    wait_valid(0, lat);
    en1 = 1'b0;
    chk("short_latency", lat, 2);
    step();
    chk("short_pc_after", pc1, 1);
    chk("short_valid_drop", val1, 0);

    // 2: long instruction via jump to 4
    q1.push_back('{4'hA, 4'h7, 8'h5C, 1'b1, 12'h004});
    ld1 = 1'b1; ldaddr1 = 12'd4;
    step();
    ld1 = 1'b0; en1 = 1'b1;
    wait_valid(0, lat);
    en1 = 1'b0;
    chk("long_latency", lat, 3);
    step();
    chk("long_pc_after", pc1, 6);

    // 3: stall for 5 cycles, then a single acceptance
    rdy1 = 1'b0; en1 = 1'b1;
    q1.push_back('{4'h1, 4'h2, 8'h00, 1'b0, 12'h006});
    wait_valid(0, lat);
    en1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", val1, 1);
      chk("stall_outs", {opc1, opr1, imm1, long1, ipc1}, {4'h1, 4'h2, 8'h00, 1'b0, 12'h006});
      step();
    end
    rdy1 = 1'b1;
    step(); step();
    chk("stall_no_dup_valid", val1, 0);
    chk("stall_queue_empty", q1.size(), 0);

    // 4: jump while capturing the first byte of the instruction at 7
    q1.push_back('{4'h3, 4'hB, 8'h00, 1'b0, 12'd10});
    en1 = 1'b1;
    step();
    ld1 = 1'b1; ldaddr1 = 12'd10;
    step();
    ld1 = 1'b0;
    chk("abort_pc", pc1, 10);
    wait_valid(0, lat);
    en1 = 1'b0;
    step();

    // Jump coinciding with ready: instruction at 20 is dropped, not accepted
    rdy1 = 1'b0;
    ld1 = 1'b1; ldaddr1 = 12'd20;
    step();
    ld1 = 1'b0; en1 = 1'b1;
    wait_valid(0, lat);
    en1 = 1'b0;
    rdy1 = 1'b1; ld1 = 1'b1; ldaddr1 = 12'd21;
    step();
    ld1 = 1'b0;
    chk("load_ready_valid", val1, 0);
    q1.push_back('{4'h6, 4'h6, 8'h00, 1'b0, 12'd21});
    en1 = 1'b1;
    wait_valid(0, lat);
    en1 = 1'b0;
    step();

    // Held load keeps pc and blocks fetch
    ld1 = 1'b1; ldaddr1 = 12'h040; en1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_load_pc", pc1, 12'h040);
      chk("held_load_valid", val1, 0);
    end
    ld1 = 1'b0; en1 = 1'b0;
    step();

    // 5: long instruction at top address wraps to 0 for its immediate
    rom[0] = 8'h22;
    q1.push_back('{4'h8, 4'h1, 8'h22, 1'b1, 12'hFFF});
    ld1 = 1'b1; ldaddr1 = 12'hFFF;
    step();
    ld1 = 1'b0; en1 = 1'b1;
    wait_valid(0, lat);
    en1 = 1'b0;
    step();
    chk("wrap_long_pc", pc1, 1);

    // 5b: same stimulus with LONG_EN=0
    q2.push_back('{4'h8, 4'h1, 8'h00, 1'b0, 12'hFFF});
    rdy2 = 1'b1;
    ld2 = 1'b1; ldaddr2 = 12'hFFF;
    step();
    ld2 = 1'b0; en2 = 1'b1;
    wait_valid(1, lat);
    en2 = 1'b0;
    chk("nolong_latency", lat, 2);
    step();
    chk("wrap_short_pc", pc2, 0);

    // 6: enable dropped during capture; pc frozen afterwards
    q1.push_back('{4'h5, 4'hA, 8'h00, 1'b0, 12'h030});
    ld1 = 1'b1; ldaddr1 = 12'h030;
    step();
    ld1 = 1'b0; en1 = 1'b1;
    step();
    en1 = 1'b0;
    wait_valid(0, lat);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("frozen_pc", pc1, 12'h031);
      chk("frozen_valid", val1, 0);
      step();
    end
    q1.push_back('{4'h7, 4'h7, 8'h00, 1'b0, 12'h031});
    en1 = 1'b1;
    wait_valid(0, lat);
    en1 = 1'b0;
    step(); step();

    chk("final_q1_empty", q1.size(), 0);
    chk("final_q2_empty", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
